// File: rtl/mult_pkg.sv
// Constants shared by the Booth-2 multiplier datapath (compressor and final adder).
// The alignment helper turns the second compressed partial product into a full-width addend.
package mult_pkg;

  localparam int PP_A_W     = 16;
  localparam int PP_B_W     = 14;
  localparam int PP_B_SHIFT = 2;
  localparam int PROD_W     = 16;

  // pp_b bit k has weight 2^(k+2), so its two low positions are implicit zeros
  function automatic logic [PROD_W-1:0] align_pp_b(input logic [PP_B_W-1:0] pp_b);
    return {pp_b, {PP_B_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/booth2_add_slice.sv
// Registered W-bit adder slice with carry-in and carry-out.
// The sum and carry registers update only when load is high.
module booth2_add_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] total_s;

  assign total_s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

  // Capture the slice sum and its carry-out on load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= {W{1'b0}};
      cout <= 1'b0;
    end else if (load) begin
      sum  <= total_s[W-1:0];
      cout <= total_s[W];
    end
  end

endmodule

// File: rtl/booth2_final_adder_pipe_chk.sv
// Handshake properties for the final adder pipeline's output port.
// Bound to the design from the outside; it has no outputs.
module booth2_final_adder_pipe_chk import mult_pkg::*; (
  input logic              clk,
  input logic              rst_n,
  input logic              in_ready,
  input logic              out_valid,
  input logic              out_ready,
  input logic [PROD_W-1:0] product
);

  // A stalled result must stay put until it is taken
  a_hold_under_stall: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(product)));

  // An empty output stage can always make room, so input must be ready
  a_ready_when_out_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !out_valid |-> in_ready);

endmodule

// File: rtl/booth2_final_adder_pipe.sv
// Final carry-propagate stage of the 8x8 Booth-2 multiplier: two-stage split adder
// with valid/ready flow control, low slice in stage 1 and high slice in stage 2.
module booth2_final_adder_pipe import mult_pkg::*; #(
  parameter int SPLIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PP_A_W-1:0] pp_a,
  input  logic [PP_B_W-1:0] pp_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product
);

  localparam int HI_W = PROD_W - SPLIT;

  logic [PROD_W-1:0] b_al_s;
  logic              en1_s;
  logic              en2_s;
  logic              v1_r;
  logic              v2_r;
  logic [SPLIT-1:0]  lo_r;
  logic              c1_r;
  logic [HI_W-1:0]   a_hi_r;
  logic [HI_W-1:0]   b_hi_r;
  logic [SPLIT-1:0]  lo_out_r;
  logic [HI_W-1:0]   hi_out_r;
  logic              hi_carry_unused_s;

  assign b_al_s = align_pp_b(pp_b);

  // Each stage may load when it is empty or the stage after it is moving
  assign en2_s     = ~v2_r | out_ready;
  assign en1_s     = ~v1_r | en2_s;
  assign in_ready  = en1_s;
  assign out_valid = v2_r;
  assign product   = {hi_out_r, lo_out_r};

  booth2_add_slice #(.W(SPLIT)) u_lo_slice (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (en1_s),
    .a     (pp_a[SPLIT-1:0]),
    .b     (b_al_s[SPLIT-1:0]),
    .cin   (1'b0),
    .sum   (lo_r),
    .cout  (c1_r)
  );

  // Stage 1 keeps the upper operand halves for the stage-2 add
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_hi_r <= {HI_W{1'b0}};
      b_hi_r <= {HI_W{1'b0}};
    end else if (en1_s) begin
      a_hi_r <= pp_a[PROD_W-1:SPLIT];
      b_hi_r <= b_al_s[PROD_W-1:SPLIT];
    end
  end

  // Carry out of bit 15 is discarded: the sign encoding makes the mod-2^16 sum exact
  booth2_add_slice #(.W(HI_W)) u_hi_slice (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (en2_s),
    .a     (a_hi_r),
    .b     (b_hi_r),
    .cin   (c1_r),
    .sum   (hi_out_r),
    .cout  (hi_carry_unused_s)
  );

  // Stage 2 forwards the already-finished low half alongside the high sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_out_r <= {SPLIT{1'b0}};
    end else if (en2_s) begin
      lo_out_r <= lo_r;
    end
  end

  // Per-stage occupancy bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r <= 1'b0;
      v2_r <= 1'b0;
    end else begin
      if (en1_s) begin
        v1_r <= in_valid;
      end
      if (en2_s) begin
        v2_r <= v1_r;
      end
    end
  end

endmodule

// File: tb/tb_booth2_final_adder_pipe.sv
// Self-checking bench: directed arithmetic/latency/backpressure/reset cases, then
// randomized signed 8x8 products split into random pp pairs, checked against a*b.
module tb_booth2_final_adder_pipe;

  localparam int NVEC = 10000;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] pp_a;
  logic [13:0] pp_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  booth2_final_adder_pipe #(.SPLIT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pp_a      (pp_a),
    .pp_b      (pp_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  booth2_final_adder_pipe_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [15:0] a, input logic [13:0] b, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    pp_a      = a;
    pp_b      = b;
    out_ready = ordy;
    #1;
  endtask

  // One pair through an empty pipe: result exactly two edges after acceptance, for one cycle
  task automatic directed(input string tag, input logic [15:0] a, input logic [13:0] b,
                          input logic [15:0] exp);
    drive(1'b1, a, b, 1'b1);
    check_val({tag, "_rdy"}, {15'd0, in_ready}, 16'd1);
    drive(1'b0, 16'd0, 14'd0, 1'b1);
    check_val({tag, "_v_early"}, {15'd0, out_valid}, 16'd0);
    drive(1'b0, 16'd0, 14'd0, 1'b1);
    check_val({tag, "_v"}, {15'd0, out_valid}, 16'd1);
    check_val({tag, "_prod"}, product, exp);
    drive(1'b0, 16'd0, 14'd0, 1'b1);
    check_val({tag, "_v_late"}, {15'd0, out_valid}, 16'd0);
  endtask

  initial begin
    logic              pend;
    logic signed [7:0] a8;
    logic signed [7:0] b8;
    logic [15:0]       prod;
    logic [15:0]       cur_a;
    logic [13:0]       cur_b;
    logic [15:0]       cur_exp;
    logic              stalled;
    logic [15:0]       held;
    int                sent;

    rst_n = 1'b0; in_valid = 1'b0; pp_a = 16'd0; pp_b = 14'd0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check_val("rst_product", product, 16'h0000);
    check_val("rst_in_ready", {15'd0, in_ready}, 16'd1);
    rst_n = 1'b1;

    directed("basic", 16'h0003, 14'h0001, 16'h0007);
    directed("carry", 16'h00FF, 14'h0001, 16'h0103);
    directed("nocarry", 16'h00FE, 14'h0000, 16'h00FE);
    directed("wrap1", 16'hFFFF, 14'h0001, 16'h0003);
    directed("wrap2", 16'h8000, 14'h2000, 16'h0000);
    directed("hicarry", 16'h0F80, 14'h0020, 16'h1000);

    // Backpressure: two accepted, third held off, then drained in order
    drive(1'b1, 16'h0001, 14'd0, 1'b0);
    check_val("bp_rdy1", {15'd0, in_ready}, 16'd1);
    drive(1'b1, 16'h0002, 14'd0, 1'b0);
    check_val("bp_rdy2", {15'd0, in_ready}, 16'd1);
    drive(1'b1, 16'h0003, 14'd0, 1'b0);
    check_val("bp_rdy3", {15'd0, in_ready}, 16'd0);
    check_val("bp_v", {15'd0, out_valid}, 16'd1);
    check_val("bp_hold1", product, 16'h0001);
    drive(1'b1, 16'h0003, 14'd0, 1'b0);
    check_val("bp_rdy4", {15'd0, in_ready}, 16'd0);
    check_val("bp_hold2", product, 16'h0001);
    drive(1'b1, 16'h0003, 14'd0, 1'b1);
    check_val("bp_rdy_rel", {15'd0, in_ready}, 16'd1);
    check_val("bp_out1", product, 16'h0001);
    drive(1'b0, 16'd0, 14'd0, 1'b1);
    check_val("bp_v2", {15'd0, out_valid}, 16'd1);
    check_val("bp_out2", product, 16'h0002);
    drive(1'b0, 16'd0, 14'd0, 1'b1);
    check_val("bp_v3", {15'd0, out_valid}, 16'd1);
    check_val("bp_out3", product, 16'h0003);
    drive(1'b0, 16'd0, 14'd0, 1'b1);
    check_val("bp_empty", {15'd0, out_valid}, 16'd0);

    // Reset in the middle of a cycle with two items held
    drive(1'b1, 16'h0011, 14'd0, 1'b0);
    drive(1'b1, 16'h0022, 14'd0, 1'b0);
    drive(1'b0, 16'd0, 14'd0, 1'b0);
    check_val("mr_full", {15'd0, out_valid}, 16'd1);
    #1 rst_n = 1'b0;
    #1;
    check_val("mr_v", {15'd0, out_valid}, 16'd0);
    check_val("mr_prod", product, 16'h0000);
    check_val("mr_rdy", {15'd0, in_ready}, 16'd1);
    #1 rst_n = 1'b1;
    drive(1'b0, 16'd0, 14'd0, 1'b1);
    check_val("mr_stale1", {15'd0, out_valid}, 16'd0);
    drive(1'b0, 16'd0, 14'd0, 1'b1);
    check_val("mr_stale2", {15'd0, out_valid}, 16'd0);
    directed("post_rst", 16'h0005, 14'h0002, 16'h000D);

    // Random end-to-end: pairs whose sum is a*b, random out_ready, scoreboard queue
    pend = 1'b0; sent = 0; stalled = 1'b0; held = 16'd0;
    cur_a = 16'd0; cur_b = 14'd0; cur_exp = 16'd0;
    for (int cyc = 0; cyc < 60000 && (sent < NVEC || exp_q.size() > 0); cyc++) begin
      @(negedge clk);
      if (!pend && sent < NVEC && $urandom_range(0, 4) != 0) begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        if (sent == 0) begin a8 = -8'sd128; b8 = -8'sd128; end
        if (sent == 1) begin a8 = -8'sd128; b8 = 8'sd127; end
        prod    = a8 * b8;
        cur_b   = 14'($urandom);
        cur_a   = prod - {cur_b, 2'b00};
        cur_exp = prod;
        pend    = 1'b1;
      end
      in_valid  = pend;
      pp_a      = cur_a;
      pp_b      = cur_b;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (stalled) begin
        check_val("stall_valid", {15'd0, out_valid}, 16'd1);
        check_val("stall_hold", product, held);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("spurious", {15'd0, out_valid}, 16'd0);
        end else begin
          check_val("e2e", product, exp_q.pop_front());
        end
      end
      stalled = out_valid && !out_ready;
      held    = product;
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_exp);
        sent++;
        pend = 1'b0;
      end
    end
    check_val("all_sent", 16'(sent), 16'(NVEC));
    check_val("drained", 16'(exp_q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
